// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared WISC opcode and fetch constants
//
// Purpose: opcode values used by the front end, fetch defaults and the
//          fetch FSM state type.
// Ports:   none (package).
package instr_fetch_pkg;

  localparam int          INSTR_W        = 16;
  localparam logic [3:0]  OP_HLT         = 4'hF;
  localparam logic [15:0] FETCH_RESET_PC = 16'h0000;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  function automatic logic is_hlt_word(input logic [INSTR_W-1:0] word);
    return word[15:12] == OP_HLT;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order prefetch FIFO with synchronous flush
//
// Purpose: DEPTH x WIDTH synchronous FIFO; head entry is presented
//          combinationally and reads as zero when empty.
// Ports:   clk, rst (sync, active-high), flush, push/push_data,
//          pop/pop_data, full, empty, count.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - WISC instruction fetch front end
//
// Purpose: issues word-addressed reads (one outstanding), buffers returned
//          words in a prefetch queue, hands them to decode over valid/ready,
//          handles redirects and a permanent halt.
// Ports:   clk, rst (sync, active-high);
//          imem_req/imem_addr, imem_rvalid/imem_rdata  - instruction memory;
//          instr/instr_pc/instr_valid/instr_ready      - decode handshake;
//          redirect/redirect_pc, hlt, halted            - control.
// Config:  FETCH_HLT_DETECT_EN - stop prefetching after a returned HLT word
//          until the next redirect or reset.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(FETCH_RESET_PC),
  parameter int                BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [15:0]        imem_rdata,
  output logic [15:0]        instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               hlt,
  output logic               halted
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int ENT_W = 16 + ADDR_W;

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              outstanding;
  logic              discard;
  logic              stall;

  logic              q_flush, q_push, q_pop, q_full, q_empty;
  logic [CNT_W-1:0]  q_count;
  logic [ENT_W-1:0]  q_head;

  fetch_queue #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENT_W)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (q_flush),
    .push      (q_push),
    .push_data ({imem_rdata, req_pc}),
    .pop       (q_pop),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Head entry is registered data; a returned word becomes visible the
  // cycle after imem_rvalid, never in the same cycle.
  assign {instr, instr_pc} = q_head;
  assign instr_valid       = !q_empty;
  assign halted            = (state == ST_HALTED);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    imem_addr  = '0;
    q_flush    = 1'b0;
    q_push     = 1'b0;
    q_pop      = 1'b0;
    case (state)
      ST_RUN: begin
        if (hlt) begin
          state_next = ST_HALTED;
          q_flush    = 1'b1;
        end else if (redirect) begin
          q_flush = 1'b1;
        end else begin
          imem_req = !outstanding && (q_count < CNT_W'(BUF_DEPTH)) && !stall;
          q_push   = imem_rvalid && outstanding && !discard && !q_full;
          q_pop    = instr_valid && instr_ready;
        end
      end
      default: ;
    endcase
    // Memory shares rst; keep the request strobe quiet while it is held.
    if (rst) imem_req = 1'b0;
    if (imem_req) imem_addr = fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else begin
      if (imem_rvalid) outstanding <= 1'b0;
      if (state == ST_RUN) begin
        if (hlt || redirect) begin
          // A response already in flight belongs to the old stream; drop it
          // when it lands. One landing this cycle is simply not pushed.
          discard <= outstanding && !imem_rvalid;
          if (!hlt) fetch_pc <= redirect_pc;
        end else begin
          if (imem_rvalid && discard) discard <= 1'b0;
          if (imem_req) begin
            outstanding <= 1'b1;
            req_pc      <= fetch_pc;
            fetch_pc    <= fetch_pc + ADDR_W'(1);
          end
        end
      end
    end
  end

`ifdef FETCH_HLT_DETECT_EN
  // The HLT word itself is still queued; only further prefetch is held off.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall <= 1'b0;
    end else if (state == ST_RUN && !hlt && redirect) begin
      stall <= 1'b0;
    end else if (q_push && is_hlt_word(imem_rdata)) begin
      stall <= 1'b1;
    end
  end
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        hlt;
  logic        halted;

  always #5 clk = ~clk;

  instr_fetch #(
    .ADDR_W    (16),
    .RESET_PC  (16'h0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .hlt         (hlt),
    .halted      (halted)
  );

  int          errors = 0;
  int          checks = 0;
  int          lat = 1;
  int          cyc = 0;
  int          first_valid = 0;
  int          hlt_at = -1;
  logic        pend_valid = 1'b0;
  logic [15:0] pend_addr = '0;
  int          pend_cnt = 0;
  logic [31:0] exp_q[$];
  logic [15:0] req_log[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (int'(a) == hlt_at) return 16'hF123;
    case (a)
      16'h0000: return 16'h1123;
      16'h0001: return 16'h2456;
      16'h0002: return 16'h3789;
      16'h0003: return 16'h4ABC;
      default:  return {4'h5, a[11:0]};
    endcase
  endfunction

  task automatic expect_pc(input logic [15:0] pc);
    exp_q.push_back({mem_word(pc), pc});
  endtask

  // One clock: called just after a falling edge with control inputs set.
  task automatic cycle();
    logic [31:0] e;
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (pend_valid) begin
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend_valid  = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    #1;
    if (instr_valid && first_valid == 0) first_valid = cyc;
    if (instr_valid && instr_ready && !redirect && !hlt && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("instr", {16'h0, instr}, {16'h0, e[31:16]});
      check_eq("instr_pc", {16'h0, instr_pc}, {16'h0, e[15:0]});
    end
    if (imem_req) begin
      req_log.push_back(imem_addr);
      pend_valid = 1'b1;
      pend_addr  = imem_addr;
      pend_cnt   = lat - 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input logic check_outs);
    rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; hlt = 1'b0;
    pend_valid = 1'b0;
    exp_q.delete();
    cycle();
    cycle();
    if (check_outs) begin
      check_eq("rst_imem_req", {31'h0, imem_req}, 32'h0);
      check_eq("rst_imem_addr", {16'h0, imem_addr}, 32'h0);
      check_eq("rst_instr", {16'h0, instr}, 32'h0);
      check_eq("rst_instr_pc", {16'h0, instr_pc}, 32'h0);
      check_eq("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
      check_eq("rst_halted", {31'h0, halted}, 32'h0);
    end
    rst = 1'b0;
    req_log.delete();
    cyc = 0;
    first_valid = 0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      instr_ready = 1'b1;
      cycle();
      n++;
    end
    instr_ready = 1'b0;
    check_eq(tag, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        redirected;
    int          n;
    int          hits;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    @(negedge clk);

    // Reset state, then in-order delivery at latency 1.
    lat = 1;
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) expect_pc(16'(i));
    drain("t1_drain", 60);
    check_eq("t1_first_valid_cycle", first_valid, 3);
    check_eq("t1_first_req_addr", {16'h0, (req_log.size() > 0) ? req_log[0] : 16'hFFFF}, 32'h0);

    // Decode stalled: queue fills to depth and requests stop.
    do_reset(1'b0);
    instr_ready = 1'b0;
    repeat (12) cycle();
    check_eq("t2_req_count", req_log.size(), 2);
    check_eq("t2_instr", {16'h0, instr}, 32'h1123);
    check_eq("t2_instr_pc", {16'h0, instr_pc}, 32'h0);
    check_eq("t2_instr_valid", {31'h0, instr_valid}, 32'h1);

    // Latency 3, redirect while address 5 is outstanding.
    lat = 3;
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) expect_pc(16'(i));
    redirected = 1'b0;
    n = 0;
    while ((!redirected || exp_q.size() > 0) && n < 300) begin
      if (!redirected && req_log.size() > 0 && req_log[$] == 16'h0005) begin
        redirect = 1'b1; redirect_pc = 16'h0040; instr_ready = 1'b0;
        redirected = 1'b1;
        cycle();
        redirect = 1'b0;
        expect_pc(16'h0040);
        expect_pc(16'h0041);
      end else begin
        instr_ready = (exp_q.size() > 0);
        cycle();
      end
      n++;
    end
    instr_ready = 1'b0;
    check_eq("t3_redirect_seen", {31'h0, redirected}, 32'h1);
    check_eq("t3_drain", exp_q.size(), 0);
    hits = 0;
    foreach (req_log[i]) if (req_log[i] == 16'h0006) hits++;
    check_eq("t3_no_req6", hits, 0);

    // hlt together with redirect: halt wins and is permanent.
    hlt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0080;
    cycle();
    hlt = 1'b0; redirect = 1'b0;
    check_eq("t4_halted", {31'h0, halted}, 32'h1);
    check_eq("t4_instr_valid", {31'h0, instr_valid}, 32'h0);
    req_log.delete();
    for (int i = 0; i < 20; i++) begin
      redirect    = 1'($urandom_range(0, 1));
      redirect_pc = 16'($urandom_range(0, 255));
      cycle();
    end
    redirect = 1'b0;
    check_eq("t4_no_req", req_log.size(), 0);
    check_eq("t4_still_halted", {31'h0, halted}, 32'h1);
    check_eq("t4_instr_valid_end", {31'h0, instr_valid}, 32'h0);

    // PC wrap from 16'hFFFF to 0.
    lat = 1;
    do_reset(1'b0);
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    cycle();
    redirect = 1'b0;
    expect_pc(16'hFFFF);
    expect_pc(16'h0000);
    drain("t5_drain", 40);
    check_eq("t5_req0", {16'h0, (req_log.size() > 0) ? req_log[0] : 16'h1234}, 32'hFFFF);
    check_eq("t5_req1", {16'h0, (req_log.size() > 1) ? req_log[1] : 16'h1234}, 32'h0000);

`ifdef FETCH_HLT_DETECT_EN
    // HLT word at address 2 stops prefetch until redirect.
    hlt_at = 2;
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) expect_pc(16'(i));
    drain("t6_drain", 60);
    repeat (10) cycle();
    check_eq("t6_req_count", req_log.size(), 3);
    check_eq("t6_last_req", {16'h0, (req_log.size() > 0) ? req_log[$] : 16'h1234}, 32'h2);
    redirect = 1'b1; redirect_pc = 16'h0010;
    cycle();
    redirect = 1'b0;
    expect_pc(16'h0010);
    drain("t6_resume", 40);
    hlt_at = -1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
